// File: rtl/riscv_top_proc_pkg.sv
// Shared definitions for the multicycle RV32I-subset core: opcodes, ALU
// operation encoding, controller states and the funct3-to-ALU decode helper.
package riscv_top_proc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_AND,
    ALU_OR,
    ALU_ADD,
    ALU_SUB,
    ALU_SLT,
    ALU_SRL,
    ALU_SLL,
    ALU_SRA,
    ALU_XOR
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB
  } state_e;

  // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_top_proc_alu.sv
// 32-bit ALU with zero flag; shifts use the low five bits of operand b.
module riscv_alu
  import riscv_top_proc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      ALU_SRL: y = a >> b[4:0];
      ALU_SLL: y = a << b[4:0];
      ALU_SRA: y = $unsigned($signed(a) >>> b[4:0]);
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/riscv_top_proc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, all registers cleared on reset.
module riscv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/riscv_top_proc.sv
// Multicycle RV32I-subset core: every instruction walks IF/ID/EX/MEM/WB,
// with register write and PC update both on the WB clock edge.
module riscv_top_proc
  import riscv_top_proc_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] dReadData,
  output logic [31:0] PC,
  output logic [31:0] dAddress,
  output logic [31:0] dWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] WriteBackData
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_q, alu_d;
  logic        zero_q, zero_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] alu_b, alu_y;
  logic        alu_zero;
  alu_op_e     alu_op;
  logic        is_r, is_imm, is_load, is_store, is_branch;
  logic        writes_rd, rf_we;

  assign opcode   = ir_q[6:0];
  assign rd_addr  = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1_addr = ir_q[19:15];
  assign rs2_addr = ir_q[24:20];

  assign is_r      = (opcode == OP_R);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign writes_rd = is_r || is_imm || is_load;

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  always_comb begin
    alu_b  = imm_i;
    alu_op = ALU_ADD;
    if (is_r || is_branch) alu_b = rs2_val;
    else if (is_store)     alu_b = imm_s;
    // bit 30 of an I-type word is immediate data except for SRLI/SRAI
    if (is_r)           alu_op = alu_from_funct(funct3, ir_q[30]);
    else if (is_imm)    alu_op = alu_from_funct(funct3, ir_q[30] && (funct3 == 3'b101));
    else if (is_branch) alu_op = ALU_SUB;
  end

  riscv_alu u_alu (
    .a    (rs1_val),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  assign rf_we = (state_q == S_WB) && writes_rd;

  riscv_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst),
    .we     (rf_we),
    .waddr  (rd_addr),
    .wdata  (WriteBackData),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    alu_d   = alu_q;
    zero_d  = zero_q;
    case (state_q)
      S_IF: begin
        ir_d    = instr;
        state_d = S_ID;
      end
      S_ID:  state_d = S_EX;
      S_EX: begin
        alu_d   = alu_y;
        zero_d  = alu_zero;
        state_d = S_MEM;
      end
      S_MEM: state_d = S_WB;
      S_WB: begin
        pc_d    = (is_branch && zero_q) ? (pc_q + imm_b) : (pc_q + 32'd4);
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      pc_q    <= INITIAL_PC;
      ir_q    <= '0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      zero_q  <= zero_d;
    end
  end

  assign PC            = pc_q;
  assign dAddress      = alu_q;
  assign dWriteData    = rs2_val;
  assign MemRead       = (state_q == S_MEM) && is_load;
  assign MemWrite      = (state_q == S_MEM) && is_store;
  assign WriteBackData = is_load ? dReadData : alu_q;

endmodule

// File: tb/tb_riscv_top_proc.sv
// Bench for riscv_top_proc: instruction-level reference model driven with
// directed and random instructions, five clocks per instruction.
module tb_riscv_top_proc;

  localparam logic [31:0] INIT_PC = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] dReadData = '0;
  logic [31:0] PC, dAddress, dWriteData, WriteBackData;
  logic        MemRead, MemWrite;

  riscv_top_proc #(.INITIAL_PC(INIT_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .dReadData     (dReadData),
    .PC            (PC),
    .dAddress      (dAddress),
    .dWriteData    (dWriteData),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .WriteBackData (WriteBackData)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = INIT_PC;
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      3'd7:    r = a & b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  // Called just after a falling edge with the core in IF; returns likewise.
  task automatic run(input logic [31:0] ins, input logic [31:0] rdata);
    logic [6:0]  op;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [31:0] a, b, imm_i, imm_s, imm_b, res, wb, npc;
    logic        wr, is_ld, is_st, has_addr;
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; r1 = ins[19:15]; r2 = ins[24:20];
    a = m_regs[r1];
    b = m_regs[r2];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    wr = 1'b0; is_ld = 1'b0; is_st = 1'b0; has_addr = 1'b1; res = '0;
    case (op)
      7'b0110011: begin res = ref_op(f3, ins[30], a, b); wr = 1'b1; end
      7'b0010011: begin res = ref_op(f3, ins[30] && (f3 == 3'd5), a, imm_i); wr = 1'b1; end
      7'b0000011: begin res = a + imm_i; wr = 1'b1; is_ld = 1'b1; end
      7'b0100011: begin res = a + imm_s; is_st = 1'b1; end
      default:    has_addr = 1'b0;
    endcase
    wb  = is_ld ? rdata : res;
    npc = (op == 7'b1100011 && a == b) ? m_pc + imm_b : m_pc + 32'd4;
    instr = ins;
    dReadData = rdata;
    repeat (3) @(posedge clk);
    #1;
    chk("mem_memread", 32'(MemRead), 32'(is_ld));
    chk("mem_memwrite", 32'(MemWrite), 32'(is_st));
    chk("mem_wdata", dWriteData, b);
    if (has_addr) chk("mem_daddr", dAddress, res);
    @(posedge clk);
    #1;
    if (wr) chk("wb_data", WriteBackData, wb);
    chk("wb_memread", 32'(MemRead), 32'd0);
    chk("wb_memwrite", 32'(MemWrite), 32'd0);
    @(posedge clk);
    #1;
    if (wr && rd != 5'd0) m_regs[rd] = wb;
    m_pc = npc;
    chk("pc", PC, m_pc);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3s [7];
    logic [2:0]  f3;
    logic [4:0]  rd, r1, r2;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [12:0] ib;
    logic [31:0] rnd;
    logic [31:0] ins;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    f3  = f3s[$urandom_range(0, 6)];
    rd  = 5'($urandom_range(0, 7));
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    rnd = $urandom;
    imm = rnd[11:0];
    ins = '0;
    case ($urandom_range(0, 5))
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && rnd[20]) ? 7'h20 : 7'h00;
        ins = {f7, r2, r1, f3, rd, 7'b0110011};
      end
      1: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = rnd[20] ? 7'h20 : 7'h00;
        ins = {imm, r1, f3, rd, 7'b0010011};
      end
      2: ins = {imm, r1, 3'b010, rd, 7'b0000011};
      3: ins = {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
      4: begin
        if (rnd[21]) r2 = r1;
        ib = {rnd[31:20], 1'b0};
        ins = {ib[12], ib[10:5], r2, r1, 3'b000, ib[4:1], ib[11], 7'b1100011};
      end
      default: ins = {rnd[31:7], 7'b0110111};
    endcase
    return ins;
  endfunction

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_pc", PC, INIT_PC);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_daddr", dAddress, 32'd0);
    chk("rst_wdata", dWriteData, 32'd0);
    chk("rst_wbdata", WriteBackData, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run(32'h00500093, 32'h0);         // ADDI x1,x0,5
    chk("addi_x1", m_regs[1], 32'd5);
    run(32'h001081B3, 32'h0);         // ADD x3,x1,x1
    run(32'h0000A103, 32'hDEADBEEF);  // LW x2,0(x1)
    run(32'h0020A223, 32'h0);         // SW x2,4(x1)
    run(32'h00000463, 32'h0);         // BEQ x0,x0,8 (taken)
    run(32'h00008463, 32'h0);         // BEQ x1,x0,8 (not taken)
    run(32'h00500013, 32'h0);         // ADDI x0,x0,5
    run(32'h00000233, 32'h0);         // ADD x4,x0,x0 -> x0 still zero
    run(32'h0000006F, 32'h0);         // unsupported opcode

    for (int n = 0; n < 150; n++) run(rand_instr(), $urandom);

    // Abort a store in MEM with an asynchronous reset pulse
    model_reset();
    m_regs[1] = 32'd0;
    instr = 32'h0020A223;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_memwrite_before", 32'(MemWrite), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_pc", PC, INIT_PC);
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_memread", 32'(MemRead), 32'd0);
    chk("abort_wbdata", WriteBackData, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    run(32'h001081B3, 32'h0);         // registers cleared: x3 = 0
    run(32'h00700293, 32'h0);         // ADDI x5,x0,7

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_top_proc.md
Name: riscv_top_proc

Overview:
- Multicycle RV32I-subset processor core; top of the CPU datapath, used with external instruction and data memories.
- Five-state controller (IF, ID, EX, MEM, WB): every instruction takes exactly 5 clock cycles.
- Contains the 32x32 register file, ALU, immediate generator and PC logic.
- Exposes the PC, data-memory interface and write-back value.

Parameters:
- INITIAL_PC, 32'h00400000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr  in  32  instruction word at address PC; sampled in IF.
- dReadData  in  32  data-memory read data; sampled in WB for LW.
- PC  out  32  program counter, registered.
- dAddress  out  32  data-memory address = registered ALU result.
- dWriteData  out  32  store data = rs2 value.
- MemRead  out  1  high only in MEM state of LW.
- MemWrite  out  1  high only in MEM state of SW.
- WriteBackData  out  32  dReadData for LW, otherwise ALU result (combinational mux).

Behaviour:
- Reset (rst low, async):
  - PC=INITIAL_PC, state=IF, instruction register=0, ALU-result register=0.
  - All 32 registers cleared; outputs therefore 0 except PC.
  - Reset mid-instruction aborts it with no register or memory write.
- FSM: IF->ID->EX->MEM->WB->IF, unconditional; one cycle per state.
- IF: latch instr into the instruction register (IR).
- ID: decode opcode/funct3/funct7; read rs1/rs2 (x0 reads 0); build immediate (I, S, B formats, sign-extended).
- EX: ALU computes; result registered (drives dAddress); zero flag registered.
- MEM: assert MemRead (LW) or MemWrite (SW), combinational from state and opcode; dWriteData=rs2.
- WB:
  - Write rd (R-type, OP-IMM, LW) on the WB clock edge; writes to x0 ignored.
  - PC update on the same edge: PC+4, or PC+immB if BEQ and rs1==rs2.
- Supported opcodes:
  - R 0110011: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
  - I 0010011: ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - LW 0000011, SW 0100011: address = rs1+imm.
  - BEQ 1100011: subtract compare.
- Arithmetic is 32-bit wrap-around. SLT/SLTI are signed. Shift amount = low 5 bits. SRA/SRAI are arithmetic.
- Unknown opcode: no register write, no memory access, PC+4.
- Register file: 2 async read ports, 1 sync write port.

Decomposition:
- Shared package holds:
  - Opcode constants.
  - ALU op encoding: AND, OR, ADD, SUB, SLT, SRL, SLL, SRA, XOR.
  - FSM state enum: IF, ID, EX, MEM, WB.
- Sub-modules: riscv_alu (ALU plus zero flag), riscv_regfile (32x32, x0 hardwired 0).
- Top holds the FSM, decode, immediate generation and PC logic.

Test Plan:
- Pulse rst low mid-cycle -> PC=0x00400000 immediately; MemRead=MemWrite=0; after release the first IF occurs on the next edge.
- instr=0x00500093 (ADDI x1,x0,5) held 5 cycles -> WriteBackData=5 in WB; PC=0x00400004 after WB.
- instr=0x001081B3 (ADD x3,x1,x1) -> WriteBackData=10; PC advances by 4.
- instr=0x0000A103 (LW x2,0(x1)), dReadData=0xDEADBEEF -> in MEM, MemRead=1 and dAddress=5; in WB, WriteBackData=0xDEADBEEF and x2 is written.
- instr=0x0020A223 (SW x2,4(x1)) -> in MEM, MemWrite=1, dAddress=9, dWriteData=0xDEADBEEF; no register write.
- instr=0x00000463 (BEQ x0,x0,8) -> PC+8. A not-taken BEQ (x1 vs x0) -> PC+4. Write to x0 -> x0 stays 0.
